// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Purpose : Shared definitions for the two-port memory arbiter: FSM state
//           encodings and the default highest legal byte address, which the
//           memory-stage address error check also uses.
// Ports   : none (package)
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Highest legal byte address for the default memory map.
  localparam int unsigned ARB_ADDR_LIMIT_DEFAULT = 1023;

  // Out-of-range test shared by the arbiter and the memory stage.
  function automatic logic addr_out_of_range(input logic [63:0] addr,
                                             input logic [63:0] limit);
    return addr > limit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_rr_grant
// Purpose : Two-input grant selection for the memory port arbiter.
//           With ARB_ROUND_ROBIN_EN defined, simultaneous requests alternate
//           using a pointer that moves to the other port after every grant.
//           Otherwise port 0 always wins (fixed priority).
// Ports   : clk_i, rst_i  clock / async active-high reset (round-robin only)
//           take          arbiter is able to accept a grant this cycle
//                         (round-robin only)
//           req0, req1    pending requests, port 0 / port 1
//           valid         at least one request pending
//           sel           selected port (0 or 1)
// Config  : ARB_ROUND_ROBIN_EN
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter_rr_grant (
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clk_i,
  input  logic rst_i,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic valid,
  output logic sel
);

  assign valid = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr names the port that wins the next tie; reset favours port 0.
  logic ptr;

  assign sel = (req0 & req1) ? ptr : req1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (take && valid) begin
      ptr <= ~sel;
    end
  end
`else
  assign sel = req1 & ~req0;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Arbitrates two requesters (port 0 = memory stage, port 1 =
//           loader/debug) onto a single-ported RAM. One transaction at a
//           time: IDLE grants and latches the request, ACCESS drives the RAM
//           for ACCESS_LAT cycles, RESP pulses the granted port's ack.
//           Out-of-range addresses skip the RAM and complete with err_o=1.
// Ports   : clk_i, rst_i              clock, async active-high reset
//           p0_*/p1_* req/we/addr/wdata  requester inputs
//           p0_ack_o, p1_ack_o         one-cycle completion pulses
//           rdata_o, err_o             response, valid only with an ack
//           p0_stall_o                 p0_req_i & ~p0_ack_o
//           ram_r_en_o, ram_w_en_o, ram_addr_o, ram_wdata_o, ram_rdata_i
//                                      RAM interface
// Config  : ARB_ROUND_ROBIN_EN selects round-robin tie-break (default fixed
//           priority, port 0 wins)
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_LAT = 2,                      // 1..15
  parameter int unsigned ADDR_LIMIT = ARB_ADDR_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [63:0] p0_addr_i,
  input  logic [63:0] p0_wdata_i,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [63:0] p1_addr_i,
  input  logic [63:0] p1_wdata_i,
  output logic        p0_ack_o,
  output logic        p1_ack_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic        p0_stall_o,
  output logic        ram_r_en_o,
  output logic        ram_w_en_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_wdata_o,
  input  logic [63:0] ram_rdata_i
);

  // The counter counts down from ACCESS_LAT-1; zero marks the last cycle.
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_LAT - 1);

  arb_state_e  state;
  arb_state_e  state_nxt;
  logic [3:0]  cnt;
  logic        gnt_port;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        err_q;
  logic [63:0] rdata_q;

  logic        any_req;
  logic        sel;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_oor;
  logic        last;

  mem_port_arbiter_rr_grant u_rr_grant (
`ifdef ARB_ROUND_ROBIN_EN
    .clk_i (clk_i),
    .rst_i (rst_i),
    .take  (state == ARB_IDLE),
`endif
    .req0  (p0_req_i),
    .req1  (p1_req_i),
    .valid (any_req),
    .sel   (sel)
  );

  assign sel_we    = sel ? p1_we_i    : p0_we_i;
  assign sel_addr  = sel ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = sel ? p1_wdata_i : p0_wdata_i;
  assign sel_oor   = addr_out_of_range(sel_addr, 64'(ADDR_LIMIT));
  assign last      = (cnt == 4'd0);

  assign p0_stall_o = p0_req_i & ~p0_ack_o;

  // State register. Async reset clears the state, which immediately drops
  // every state-decoded output (enables, acks, RAM address/data, response).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; every output is decoded from state so nothing
  // leaks onto the RAM or response buses outside its own phase.
  always_comb begin
    state_nxt   = state;
    ram_r_en_o  = 1'b0;
    ram_w_en_o  = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    p0_ack_o    = 1'b0;
    p1_ack_o    = 1'b0;
    rdata_o     = '0;
    err_o       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_nxt = sel_oor ? ARB_RESP : ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        ram_r_en_o  = ~we_q;
        ram_w_en_o  = we_q;
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
        if (last) begin
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        p0_ack_o  = ~gnt_port;
        p1_ack_o  = gnt_port;
        rdata_o   = rdata_q;
        err_o     = err_q;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Transaction latches and latency counter. Requester inputs are sampled
  // only at grant, so later changes on them are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      gnt_port <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            gnt_port <= sel;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            err_q    <= sel_oor;
            rdata_q  <= '0;       // stays zero for writes and errors
            cnt      <= CNT_INIT;
          end
        end
        ARB_ACCESS: begin
          if (!last) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            rdata_q <= ram_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter (ACCESS_LAT=2,
//           ADDR_LIMIT=1023). Stimulus pushes expected responses into a
//           scoreboard queue; a monitor on the falling edge pops and compares
//           on every ack and checks RAM activity against the queue head.
// Config  : honours ARB_ROUND_ROBIN_EN for the expected grant order
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [63:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic [63:0] ram_rdata = '0;
  logic        p0_ack_o, p1_ack_o, err_o, p0_stall_o, ram_r_en_o, ram_w_en_o;
  logic [63:0] rdata_o, ram_addr_o, ram_wdata_o;

  mem_port_arbiter #(.ACCESS_LAT(LAT), .ADDR_LIMIT(1023)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p0_ack_o(p0_ack_o), .p1_ack_o(p1_ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .p0_stall_o(p0_stall_o), .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    bit          err;
    int          rcyc;
    int          wcyc;
    int          t0;
    int          lat;   // -1: latency not checked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  int rcnt = 0, wcnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rcnt = 0;
        wcnt = 0;
      end else begin
        chk(p0_stall_o === (p0_req & ~p0_ack_o), "stall", 64'(p0_stall_o),
            64'(p0_req & ~p0_ack_o));
        if (ram_r_en_o || ram_w_en_o) begin
          if (ram_r_en_o) rcnt++;
          if (ram_w_en_o) wcnt++;
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_ram_en", 64'({ram_r_en_o, ram_w_en_o}), 64'd0);
          end else begin
            chk(ram_addr_o === sb[0].addr, "ram_addr", ram_addr_o, sb[0].addr);
            chk(!(ram_r_en_o && ram_w_en_o), "both_en", 64'd3, 64'd0);
            if (ram_w_en_o)
              chk(ram_wdata_o === sb[0].wdata, "ram_wdata", ram_wdata_o, sb[0].wdata);
          end
        end
        if (p0_ack_o || p1_ack_o) begin
          chk(!(p0_ack_o && p1_ack_o), "dual_ack", 64'({p0_ack_o, p1_ack_o}), 64'd0);
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_ack", 64'({p0_ack_o, p1_ack_o}), 64'd0);
          end else begin
            e = sb.pop_front();
            chk(p1_ack_o == e.port, "ack_port", 64'(p1_ack_o), 64'(e.port));
            chk(rdata_o === e.rdata, "rdata", rdata_o, e.rdata);
            chk(err_o === e.err, "err", 64'(err_o), 64'(e.err));
            chk(rcnt == e.rcyc, "r_en_cycles", 64'(rcnt), 64'(e.rcyc));
            chk(wcnt == e.wcyc, "w_en_cycles", 64'(wcnt), 64'(e.wcyc));
            if (e.lat >= 0)
              chk(cyc - e.t0 == e.lat, "latency", 64'(cyc - e.t0), 64'(e.lat));
          end
          rcnt = 0;
          wcnt = 0;
        end else begin
          chk(rdata_o === 64'd0 && err_o === 1'b0, "idle_resp_zero", rdata_o | 64'(err_o), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p0_ack_o || p1_ack_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  // One transaction from an idle arbiter. perturb (port 0 only) changes the
  // held inputs after grant and pulses a port-1 request that must be ignored.
  task automatic do_txn(input bit port, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] ramd,
                        input bit perturb);
    exp_t e;
    bit   oor;
    bit   got;
    oor     = addr > 64'd1023;
    e.port  = port;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = oor;
    e.rdata = (oor || we) ? 64'd0 : ramd;
    e.rcyc  = (oor || we) ? 0 : LAT;
    e.wcyc  = (!oor && we) ? LAT : 0;
    e.lat   = oor ? 1 : LAT + 1;
    @(posedge clk); #1;
    e.t0 = cyc;
    sb.push_back(e);
    ram_rdata = ramd;
    if (port) begin
      p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    if (perturb) begin
      @(posedge clk); #1;
      p0_addr  = addr ^ 64'hFF0;
      p0_wdata = ~wdata;
      p0_we    = ~we;
      p1_req = 1; p1_we = 0; p1_addr = 64'd64;
      @(posedge clk); #1;
      p1_req = 0;
    end
    wait_ack(got);
    chk(got, "ack_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    bit   got;
    int   t;
    bit   order [4];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(!p0_ack_o && !p1_ack_o, "rst_acks", 64'({p0_ack_o, p1_ack_o}), 64'd0);
    chk(!ram_r_en_o && !ram_w_en_o, "rst_en", 64'({ram_r_en_o, ram_w_en_o}), 64'd0);
    chk(ram_addr_o === 64'd0, "rst_ram_addr", ram_addr_o, 64'd0);
    chk(ram_wdata_o === 64'd0, "rst_ram_wdata", ram_wdata_o, 64'd0);
    chk(rdata_o === 64'd0 && err_o === 1'b0, "rst_resp", rdata_o | 64'(err_o), 64'd0);
    chk(p0_stall_o === 1'b0, "rst_stall", 64'(p0_stall_o), 64'd0);
    rst = 0;

    // Contention: both ports request continuously for 4 transactions
`ifdef ARB_ROUND_ROBIN_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(posedge clk); #1;
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      e.port  = order[i];
      e.addr  = order[i] ? 64'd24 : 64'd8;
      e.wdata = '0;
      e.rdata = 64'h1234;
      e.err   = 1'b0;
      e.rcyc  = LAT;
      e.wcyc  = 0;
      e.t0    = t;
      e.lat   = -1;
      sb.push_back(e);
    end
    ram_rdata = 64'h1234;
    p0_req = 1; p0_addr = 64'd8;
    p1_req = 1; p1_addr = 64'd24;
    for (int i = 0; i < 4; i++) begin
      wait_ack(got);
      chk(got, "contention_ack_timeout", 64'(got), 64'd1);
    end
    @(posedge clk); #1;
    clear_inputs();

    do_txn(1'b0, 1'b0, 64'd16,   64'd0,      64'hDEAD, 1'b0); // port-0 read
    do_txn(1'b1, 1'b1, 64'd1023, 64'h55,     64'h0,    1'b0); // port-1 write at limit
    do_txn(1'b0, 1'b0, 64'd1024, 64'd0,      64'hBEEF, 1'b0); // out of range
    do_txn(1'b0, 1'b1, 64'd200,  64'hA5A5,   64'h0,    1'b1); // inputs change after grant
    do_txn(1'b1, 1'b0, 64'd0,    64'd0,      64'hCAFE, 1'b0); // port-1 read at 0
    do_txn(1'b1, 1'b1, 64'd4096, 64'h77,     64'h0,    1'b0); // port-1 out of range write

    // Reset during the second ACCESS cycle
    @(posedge clk); #1;
    e.port = 0; e.addr = 64'd40; e.wdata = '0; e.rdata = 64'h99; e.err = 0;
    e.rcyc = LAT; e.wcyc = 0; e.t0 = cyc; e.lat = LAT + 1;
    sb.push_back(e);
    ram_rdata = 64'h99;
    p0_req = 1; p0_addr = 64'd40;
    @(posedge clk);
    @(posedge clk); #1;
    chk(ram_r_en_o === 1'b1, "pre_reset_ren", 64'(ram_r_en_o), 64'd1);
    rst = 1;
    #1;
    chk(!ram_r_en_o && !ram_w_en_o, "reset_drops_en", 64'({ram_r_en_o, ram_w_en_o}), 64'd0);
    chk(ram_addr_o === 64'd0, "reset_drops_addr", ram_addr_o, 64'd0);
    clear_inputs();
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    repeat (6) @(posedge clk);   // monitor flags any stray ack
    do_txn(1'b0, 1'b0, 64'd48, 64'd0, 64'h5A5A, 1'b0);

    repeat (3) @(posedge clk);
    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ACCESS_LAT, default 2, sets the RAM access cycles per transaction (legal range 1..15).
REQ-002 Parameter ADDR_LIMIT, default 1023, is the highest legal byte address.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 p0_req_i / p1_req_i  in  1  request, port 0 (memory stage) / port 1 (loader/debug).
REQ-006 p0_we_i / p1_we_i  in  1  1 = write, 0 = read.
REQ-007 p0_addr_i / p1_addr_i  in  64  byte address.
REQ-008 p0_wdata_i / p1_wdata_i  in  64  write data.
REQ-009 p0_ack_o / p1_ack_o  out  1  one-cycle completion pulse.
REQ-010 rdata_o  out  64  read data; valid only while an ack is high.
REQ-011 err_o  out  1  address error; valid only while an ack is high.
REQ-012 p0_stall_o  out  1  pipeline stall, equal to p0_req_i AND NOT p0_ack_o.
REQ-013 ram_r_en_o / ram_w_en_o  out  1  RAM read/write enables.
REQ-014 ram_addr_o / ram_wdata_o  out  64  RAM address and write data.
REQ-015 ram_rdata_i  in  64  RAM read data, valid in the last ACCESS cycle.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 IDLE, no request pending: stay in IDLE with all RAM enables low.
REQ-018 IDLE, one or more requests pending:
- select a grant per REQ-026;
- latch the requester's we, addr and wdata;
- go to RESP with err=1 if addr > ADDR_LIMIT (RAM untouched);
- otherwise go to ACCESS.
REQ-019 ACCESS behaviour:
- hold ram_addr_o and ram_wdata_o from the latched values;
- assert exactly one of ram_r_en_o or ram_w_en_o for ACCESS_LAT cycles;
- on the last cycle, capture ram_rdata_i (reads only) and go to RESP.
REQ-020 RESP behaviour:
- pulse the granted port's ack for exactly one cycle;
- drive captured rdata_o and err_o;
- return to IDLE.
REQ-021 Outside RESP, rdata_o and err_o SHALL be 0; for writes, rdata_o SHALL be 0.
REQ-022 In-range latency from grant to ack SHALL be ACCESS_LAT+1 cycles; out-of-range latency SHALL be 1 cycle.
REQ-023 Requesters hold req, we, addr and wdata until ack; changes to these inputs after grant SHALL be ignored.
REQ-024 A request still high in the cycle after ack SHALL be treated as a new transaction.
REQ-025 The arbiter SHALL NOT assert both acks in the same cycle, and SHALL NOT assert an ack for a port that was not granted.
REQ-026 Grant selection with simultaneous requests in IDLE is set by configuration (REQ-030).
REQ-027 A request dropped before grant SHALL be discarded without side effects.

Reset
REQ-028 While rst_i is high:
- state = IDLE;
- all acks, RAM enables, ram_addr_o, ram_wdata_o, rdata_o and err_o = 0;
- the round-robin pointer favours port 0.
REQ-029 Reset asserted mid-transaction SHALL drop the RAM enables immediately, abandon the transaction with no ack, and leave a partially timed write undefined in RAM.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL alternate grants via a pointer that flips to the other port after each grant.
REQ-031 Without ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (fixed priority); port 1 can starve.

Structure
REQ-032 The shared define file SHALL hold:
- the FSM state encodings (ARB_IDLE, ARB_ACCESS, ARB_RESP);
- the default ADDR_LIMIT constant, shared with the memory-stage error check.
REQ-033 The FSM, latency counter and grant logic SHALL be one module; sub-module rr_grant holds the two-input grant selection and pointer.

Verification
REQ-034 Port-0 read, ACCESS_LAT=2:
- stimulus: addr=16, RAM returns 0xDEAD;
- response: p0_ack_o exactly 3 cycles after grant, rdata_o=0xDEAD, err_o=0, ram_r_en_o high for 2 cycles.
REQ-035 Port-1 write: addr=1023, wdata=0x55 -> ram_w_en_o high for 2 cycles with addr 1023, then p1_ack_o pulses with err_o=0.
REQ-036 Out of range: port-0 addr=1024 -> p0_ack_o the cycle after grant, err_o=1, RAM enables never asserted.
REQ-037 Both ports request continuously for 4 transactions:
- with ARB_ROUND_ROBIN_EN: grant order 0,1,0,1;
- without it: 0,0,0,0;
- no cycle ever has both acks high.
REQ-038 Reset mid-operation: rst_i pulsed during the second ACCESS cycle -> enables low the same cycle, no ack, and a port-0 request after reset is granted from IDLE normally.
REQ-039 Stall: p0_stall_o tracks p0_req_i and falls exactly in the p0_ack_o cycle.
